// File: rtl/sseg_capture.sv
// Seven-segment readback: settles, decodes and frames
// the multiplexed SSeg/an lines into a 4-digit snapshot.
module sseg_capture #(
  parameter int SETTLE     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        CLK_50,
  input  logic        rst,
  input  logic [0:6]  SSeg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        err,
  output logic        frame_valid
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TOP  = CW'(SETTLE);

  typedef enum logic {
    COLLECT,
    COMMIT
  } state_t;

  state_t state;
  state_t state_d;

  logic [0:6]    seg_d;
  logic [0:6]    seg_q;
  logic [3:0]    an_d;
  logic [3:0]    an_q;
  logic [3:0]    an_m1;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          onehot;
  logic          take;
  logic          commit;
  logic [1:0]    slot;
  logic [3:0]    nib;
  logic          nib_blank;
  logic          nib_err;
  logic [15:0]   sh_dig;
  logic [3:0]    sh_blank;
  logic [3:0]    sh_err;
  logic [3:0]    err_d;
  logic [3:0]    seen;
  logic [3:0]    seen_d;

  assign seg_d = ACTIVE_LOW ? ~SSeg : SSeg;
  assign an_d  = ACTIVE_LOW ? ~an : an;
  assign an_m1 = an_d - 4'd1;

  // Stability is judged on the word about to be
  // registered, so cnt tracks how long in_q has held.
  assign onehot = (an_d != 4'h0)
               && ((an_d & an_m1) == 4'h0);
  assign stable = (seg_d == seg_q) && (an_d == an_q);
  assign take   = stable && onehot && (cnt == LAST);

  always_comb begin
    slot = 2'd0;
    case (an_q)
      4'b0001: slot = 2'd0;
      4'b0010: slot = 2'd1;
      4'b0100: slot = 2'd2;
      4'b1000: slot = 2'd3;
      default: slot = 2'd0;
    endcase
  end

  always_comb begin
    nib       = 4'h0;
    nib_blank = 1'b0;
    nib_err   = 1'b0;
    case (seg_q)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1001111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
      7'b0000000: nib_blank = 1'b1;
      default:    nib_err = 1'b1;
    endcase
  end

  // A sample in the commit cycle lands in the
  // freshly cleared seen/err set for the next frame.
  always_comb begin
    seen_d = commit ? 4'h0 : seen;
    err_d  = commit ? 4'h0 : sh_err;
    if (take) begin
      seen_d[slot] = 1'b1;
      err_d[slot]  = nib_err;
    end
  end

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    unique case (state)
      COLLECT: begin
        if (seen_d == 4'hF) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (rst) state <= COLLECT;
    else     state <= state_d;
  end

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
      cnt   <= '0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (!stable || !onehot) cnt <= '0;
      else if (cnt != TOP)    cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      seen     <= '0;
      sh_err   <= '0;
      sh_dig   <= '0;
      sh_blank <= '0;
    end else begin
      seen   <= seen_d;
      sh_err <= err_d;
      if (take) begin
        sh_dig[{slot, 2'b00} +: 4] <= nib;
        sh_blank[slot]             <= nib_blank;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      digits      <= '0;
      blank       <= 4'hF;
      err         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= commit;
      if (commit) begin
        digits <= sh_dig;
        blank  <= sh_blank;
        err    <= |sh_err;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: step table plus hand
// sequences, frames checked through a queue.
module tb_sseg_capture;

  localparam bit AL = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        err;
  logic        frame_valid;

  always #5 clk = ~clk;

  sseg_capture #(
    .SETTLE(4),
    .ACTIVE_LOW(AL)
  ) dut (
    .CLK_50(clk),
    .rst(rst),
    .SSeg(seg),
    .an(an),
    .digits(digits),
    .blank(blank),
    .err(err),
    .frame_valid(frame_valid)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  b;
    logic        e;
  } frame_t;

  typedef struct {
    logic [3:0] a;
    int         code;
    int         hold;
    bit         push;
    frame_t     f;
    int         fr;
  } vec_t;

  frame_t expq[$];
  vec_t   tbl[27];
  int     total = 0;
  int     bad = 0;
  int     nframes = 0;
  int     fr0;
  int     first;

  // code 16 = dark, 17 = undecodable 1010101
  function automatic logic [0:6] seg_of(int c);
    case (c)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      16: return 7'b0000000;
      default: return 7'b1010101;
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic monitor();
    frame_t f;
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        nframes++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected got=%h exp=none",
                   {digits, blank, err});
        end else begin
          f = expq.pop_front();
          check("frame", {11'b0, digits, blank, err},
                {11'b0, f});
        end
      end
    end
  endtask

  task automatic put(input logic [3:0] a, input int c);
    seg = AL ? ~seg_of(c) : seg_of(c);
    an  = AL ? ~a : a;
  endtask

  task automatic step(input logic [3:0] a, input int c,
                      input int n);
    put(a, c);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic vec_t v(logic [3:0] a, int c, int h,
                             bit p, logic [15:0] d,
                             logic [3:0] b, logic e, int fr);
    vec_t r;
    r.a = a; r.code = c; r.hold = h; r.push = p;
    r.f = '{d: d, b: b, e: e};
    r.fr = fr;
    return r;
  endfunction

  task automatic check_reset(input string nm);
    check({nm, "_digits"}, {16'b0, digits}, 32'h0);
    check({nm, "_blank"}, {28'b0, blank}, 32'hF);
    check({nm, "_err"}, {31'b0, err}, 32'h0);
    check({nm, "_fv"}, {31'b0, frame_valid}, 32'h0);
  endtask

  initial begin
    // glitch rejection, then retry
    tbl[0]  = v(4'b0001, 1, 8, 0, 16'h0, 4'h0, 0, 0);
    tbl[1]  = v(4'b0010, 2, 4, 0, 16'h0, 4'h0, 0, 0);
    tbl[2]  = v(4'b0100, 3, 8, 0, 16'h0, 4'h0, 0, 0);
    tbl[3]  = v(4'b1000, 4, 8, 0, 16'h0, 4'h0, 0, 0);
    tbl[4]  = v(4'b0010, 2, 5, 1, 16'h4321, 4'h0, 0, 0);
    tbl[5]  = v(4'b0000, 8, 4, 0, 16'h0, 4'h0, 0, 1);
    // non-one-hot gaps
    tbl[6]  = v(4'b0001, 1, 8, 0, 16'h0, 4'h0, 0, 1);
    tbl[7]  = v(4'b1111, 8, 10, 0, 16'h0, 4'h0, 0, 1);
    tbl[8]  = v(4'b0010, 2, 8, 0, 16'h0, 4'h0, 0, 1);
    tbl[9]  = v(4'b0011, 8, 10, 0, 16'h0, 4'h0, 0, 1);
    tbl[10] = v(4'b0100, 3, 8, 0, 16'h0, 4'h0, 0, 1);
    tbl[11] = v(4'b1111, 3, 10, 0, 16'h0, 4'h0, 0, 1);
    tbl[12] = v(4'b1000, 4, 8, 1, 16'h4321, 4'h0, 0, 2);
    // blank and invalid, then clean frame
    tbl[13] = v(4'b1000, 16, 8, 0, 16'h0, 4'h0, 0, 2);
    tbl[14] = v(4'b0100, 5, 8, 0, 16'h0, 4'h0, 0, 2);
    tbl[15] = v(4'b0010, 17, 8, 0, 16'h0, 4'h0, 0, 2);
    tbl[16] = v(4'b0001, 6, 8, 1, 16'h0506, 4'h8, 1, 3);
    tbl[17] = v(4'b0001, 1, 8, 0, 16'h0, 4'h0, 0, 3);
    tbl[18] = v(4'b0010, 2, 8, 0, 16'h0, 4'h0, 0, 3);
    tbl[19] = v(4'b0100, 3, 8, 0, 16'h0, 4'h0, 0, 3);
    tbl[20] = v(4'b1000, 4, 8, 1, 16'h4321, 4'h0, 0, 4);
    tbl[21] = v(4'b0000, 8, 4, 0, 16'h0, 4'h0, 0, 4);
    // resample overwrite on an[0]
    tbl[22] = v(4'b0001, 7, 8, 0, 16'h0, 4'h0, 0, 4);
    tbl[23] = v(4'b0001, 9, 8, 0, 16'h0, 4'h0, 0, 4);
    tbl[24] = v(4'b0010, 2, 8, 0, 16'h0, 4'h0, 0, 4);
    tbl[25] = v(4'b0100, 3, 8, 0, 16'h0, 4'h0, 0, 4);
    tbl[26] = v(4'b1000, 4, 8, 1, 16'h4329, 4'h0, 0, 5);

    rst = 1'b1;
    put(4'b0000, 8);
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // full frame with commit latency
    step(4'b0001, 1, 8);
    step(4'b0010, 2, 8);
    step(4'b0100, 3, 8);
    expq.push_back('{d: 16'h4321, b: 4'h0, e: 1'b0});
    put(4'b1000, 4);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      if (first == 0 && frame_valid === 1'b1) first = i;
    end
    check("t1_latency", first, 6);
    check("t1_frames", nframes, 1);

    fr0 = nframes;
    foreach (tbl[i]) begin
      if (tbl[i].push) expq.push_back(tbl[i].f);
      step(tbl[i].a, tbl[i].code, tbl[i].hold);
      check($sformatf("step%0d_frames", i), nframes,
            fr0 + tbl[i].fr);
    end

    // reset after two samples discards them
    fr0 = nframes;
    step(4'b0001, 1, 8);
    step(4'b0010, 2, 8);
    rst = 1'b1;
    put(4'b0000, 8);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check_reset("midrst");
    step(4'b0100, 3, 8);
    step(4'b1000, 4, 8);
    check("midrst_nocommit", nframes, fr0);
    step(4'b0001, 5, 8);
    expq.push_back('{d: 16'h4365, b: 4'h0, e: 1'b0});
    step(4'b0010, 6, 8);
    check("midrst_commit", nframes, fr0 + 1);

    step(4'b0000, 8, 20);
    check("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receive-side counterpart of the multiplexed 4-digit seven-segment display driver. It watches the `SSeg`/`an` lines the driver produces, waits for each digit to settle, and decodes the segment pattern back to a hex nibble. Once every digit position has been sampled, it commits a coherent 4-digit frame. It sits beside the display driver, in hardware or in benches, to read back what the display shows without scraping waveforms.

## Interface

**Parameters**

- `SETTLE`, default 4: consecutive stable cycles required before a digit is sampled (≥1).
- `ACTIVE_LOW`, default 1: 1 means `SSeg` and `an` are active-low; 0 means active-high.

**Ports**

- `CLK_50` in 1: system clock; one clock domain only.
- `rst` in 1: synchronous reset, active-high.
- `SSeg` in [0:6]: segment lines; `SSeg[0]`=a … `SSeg[6]`=g.
- `an` in [3:0]: digit enables; `an[0]` is the rightmost digit.
- `digits` out [15:0]: last committed frame; `digits[3:0]` belongs to `an[0]`.
- `blank` out [3:0]: per-digit flag, set when that digit was dark in the last frame.
- `err` out 1: set when the last committed frame contained an undecodable pattern.
- `frame_valid` out 1: one-cycle pulse on every commit.

## Operation

- **Input polarity:** inputs are registered once (`in_q`). When `ACTIVE_LOW`=1, the inputs are inverted to logical-high before any other use.
- **Stability counter `cnt`:**
  - Cleared to 0 whenever `in_q` differs from its previous-cycle value.
  - Cleared to 0 whenever `in_q.an` is not one-hot (all-off or more than one active).
  - Otherwise increments, saturating at `SETTLE`.
- **Sampling:** a sample happens exactly once per stable window, on the cycle `cnt` goes from `SETTLE-1` to `SETTLE`. The sample decodes the segments into shadow slot `i`, where `i` is the active `an` bit, and sets `seen[i]`.
- **Decode table** (logical `SSeg[0:6]`):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - 0000000 → nibble 0 with shadow blank bit set.
  - Any other pattern → nibble 0 with shadow error bit set.
- **Resampling:** a slot resampled before commit is overwritten; the latest sample wins, including its blank and error bits.
- **States:**
  - COLLECT: `seen` is not 1111.
  - COMMIT: `seen` is 1111, for one cycle. The block copies shadow to `digits`/`blank`, sets `err` to the OR of the four error bits, pulses `frame_valid`, clears `seen` and the error bits, and returns to COLLECT.
  - A sample arriving in the COMMIT cycle is kept for the next frame.
- **Holding outputs:** outputs hold between commits. `err` is not sticky across frames.
- **Out-of-order digits:** scan order is irrelevant; any order that covers all four slots commits.

## Timing

- **Reset values:** `digits`=0, `blank`=4'b1111, `err`=0, `frame_valid`=0, `seen`=0, `cnt`=0, shadow cleared.
- **Sampling latency:** inputs are applied before edge k and held. `in_q` updates at k, and the sample is taken at edge k+`SETTLE`. A digit therefore needs at least `SETTLE`+1 cycles on the bus to be sampled.
- **Commit latency:** the commit registers and `frame_valid` assert at the edge after the sample that completes `seen`.
- **Throughput:** minimum frame is 4·(`SETTLE`+1) cycles; there is no back-pressure.
- **Reset mid-frame:** shadow and `seen` are discarded. The next frame needs all four digits sampled after reset release.
- **Simultaneous sample and commit:** the commit uses the pre-sample shadow, and the new sample lands in the cleared `seen`.

## Test plan

1. **Full hex frame.** `SETTLE`=4, active-low. Drive patterns for 1,2,3,4 on `an`=1110,1101,1011,0111, each held 8 cycles. Expect one `frame_valid` pulse 6 cycles after the last digit appears, with `digits`=16'h4321, `blank`=0000, `err`=0.
2. **Glitch rejection.** Same as scenario 1, but hold digit 2 for only 4 cycles. Expect no `frame_valid`. Then hold it for 5 cycles and expect a commit.
3. **Non-one-hot enables.** Insert `an`=4'b1111 and `an`=4'b0011 gaps of 10 cycles between digits. Expect no samples during the gaps; the frame still commits 16'h4321.
4. **Blank and invalid patterns.** Digit 3 dark (all segments off) and digit 1 driven with 1010101, digits 2 and 0 showing 5 and 6. Expect `digits`=16'h0506, `blank`=1000, `err`=1. On the next clean frame `err` returns to 0.
5. **Reset mid-frame.** Pulse `rst` for one cycle after two digits have been sampled. Expect all outputs at reset values and no commit until four fresh samples are taken.
6. **Resample overwrite.** Show 7 on `an[0]`, then 9 on `an[0]` before the other three digits. Expect the commit to show `digits[3:0]`=9.
